hazard_stall_ctrl: RTL and testbench

// Pipeline sequencing controller for the 5-stage semiMIPS core, next to the forwarding unit.

---
 rtl/hazard_stall_ctrl_pkg.sv | 39 +++
 rtl/hazard_stall_ctrl_mem_wait_timer.sv | 42 ++++
 rtl/hazard_stall_ctrl.sv | 91 +++++++++
 tb/tb_hazard_stall_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the semiMIPS hazard/stall controller: FSM encodings,
// pipeline control bundle and the load-use hazard detector.
package hazard_stall_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    typedef struct packed {
        logic pcwrite;
        logic ifidwrite;
        logic ifidflush;
        logic idexwrite;
        logic idexbubble;
        logic exmemwrite;
        logic memwbbubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{pcwrite: 1'b0, ifidwrite: 1'b0, ifidflush: 1'b1,
                                     idexwrite: 1'b0, idexbubble: 1'b1, exmemwrite: 1'b0,
                                     memwbbubble: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{pcwrite: 1'b0, ifidwrite: 1'b0, ifidflush: 1'b0,
                                      idexwrite: 1'b0, idexbubble: 1'b0, exmemwrite: 1'b0,
                                      memwbbubble: 1'b1};
    localparam ctrl_t CTRL_FLOW = '{pcwrite: 1'b1, ifidwrite: 1'b1, ifidflush: 1'b0,
                                    idexwrite: 1'b1, idexbubble: 1'b0, exmemwrite: 1'b1,
                                    memwbbubble: 1'b0};

    // $0 is never a real destination, so a load into it cannot create a hazard.
    function automatic logic load_use(input logic             memrd,
                                      input logic [REG_W-1:0] exrt,
                                      input logic [REG_W-1:0] rs,
                                      input logic [REG_W-1:0] rt,
                                      input logic             usert);
        return memrd && (exrt != '0) && ((exrt == rs) || (usert && (exrt == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mem_wait_timer.sv
// Data-memory wait timer: counts cycles spent in MEM_WAIT and raises a sticky
// error once an access has waited MEM_TIMEOUT cycles without completing.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic memerr
);
    import hazard_stall_ctrl_pkg::*;

    logic [15:0] waitcnt_q, waitcnt_d;
    logic        memerr_q, memerr_d;

    always_comb begin
        waitcnt_d = waitcnt_q;
        memerr_d  = memerr_q;
        if (start) begin
            waitcnt_d = 16'd1;
        end else if (hold) begin
            if (waitcnt_q == 16'(MEM_TIMEOUT)) memerr_d = 1'b1;
            if (waitcnt_q != 16'hffff) waitcnt_d = waitcnt_q + 16'd1;
        end else begin
            waitcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waitcnt_q <= '0;
            memerr_q  <= 1'b0;
        end else begin
            waitcnt_q <= waitcnt_d;
            memerr_q  <= memerr_d;
        end
    end

    assign memerr = memerr_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// whole-pipeline freeze while data memory is busy.
//   state    | meaning
//   RUN      | pipeline flowing, hazards resolved combinationally
//   MEM_WAIT | data access outstanding, every stage frozen
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idexmemrd,
    input  logic [4:0]       idexrt,
    input  logic [4:0]       ifidrs,
    input  logic [4:0]       ifidrt,
    input  logic             ifidusert,
    input  logic             branchtaken,
    input  logic             dmemreq,
    input  logic             dmemready,
    output logic             pcwrite,
    output logic             ifidwrite,
    output logic             ifidflush,
    output logic             idexwrite,
    output logic             idexbubble,
    output logic             exmemwrite,
    output logic             memwbbubble,
    output logic [CNT_W-1:0] stallcycles,
    output logic             memerr
);
    import hazard_stall_ctrl_pkg::*;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    ctrl_t            ctrl;
    logic             frozen, timer_start, timer_hold;

    always_comb begin
        // In MEM_WAIT only a completed access releases the freeze; dmemready
        // without dmemreq never counts as completion.
        if (state_q == ST_MEM_WAIT) frozen = !(dmemreq && dmemready);
        else                        frozen = dmemreq && !dmemready;

        ctrl = CTRL_FLOW;
        if (frozen) begin
            ctrl = CTRL_FREEZE;
        end else if (branchtaken) begin
            ctrl.ifidflush  = 1'b1;
            ctrl.idexbubble = 1'b1;
        end else if (load_use(idexmemrd, idexrt, ifidrs, ifidrt, ifidusert)) begin
            ctrl.pcwrite    = 1'b0;
            ctrl.ifidwrite  = 1'b0;
            ctrl.idexbubble = 1'b1;
        end
        if (rst) ctrl = CTRL_RESET;

        state_d     = frozen ? ST_MEM_WAIT : ST_RUN;
        timer_start = frozen && (state_q == ST_RUN);
        timer_hold  = frozen && (state_q == ST_MEM_WAIT);

        stall_d = stall_q;
        if (!ctrl.pcwrite && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
        end
    end

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .start  (timer_start),
        .hold   (timer_hold),
        .memerr (memerr)
    );

    assign pcwrite     = ctrl.pcwrite;
    assign ifidwrite   = ctrl.ifidwrite;
    assign ifidflush   = ctrl.ifidflush;
    assign idexwrite   = ctrl.idexwrite;
    assign idexbubble  = ctrl.idexbubble;
    assign exmemwrite  = ctrl.exmemwrite;
    assign memwbbubble = ctrl.memwbbubble;
    assign stallcycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed hazard scenarios followed by random
// traffic, all checked against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int TIMEOUT   = 4;
    localparam int CW        = 4;
    localparam int STALL_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, idexmemrd, ifidusert, branchtaken, dmemreq, dmemready;
    logic [4:0]    idexrt, ifidrs, ifidrt;
    logic          pcwrite, ifidwrite, ifidflush, idexwrite, idexbubble, exmemwrite, memwbbubble;
    logic [CW-1:0] stallcycles;
    logic          memerr;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state
    bit m_known = 0;
    bit m_wait  = 0;
    int m_wcnt  = 0;
    bit m_err   = 0;
    int m_stall = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .idexmemrd(idexmemrd), .idexrt(idexrt), .ifidrs(ifidrs),
        .ifidrt(ifidrt), .ifidusert(ifidusert), .branchtaken(branchtaken), .dmemreq(dmemreq),
        .dmemready(dmemready), .pcwrite(pcwrite), .ifidwrite(ifidwrite), .ifidflush(ifidflush),
        .idexwrite(idexwrite), .idexbubble(idexbubble), .exmemwrite(exmemwrite),
        .memwbbubble(memwbbubble), .stallcycles(stallcycles), .memerr(memerr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {pcwrite, ifidwrite, ifidflush, idexwrite, idexbubble, exmemwrite, memwbbubble}
    function automatic logic [6:0] expect_ctrl(input bit frz);
        bit lu;
        if (rst) return 7'b0010101;
        if (frz) return 7'b0000001;
        if (branchtaken) return 7'b1111110;
        lu = idexmemrd && idexrt != 0 &&
             (idexrt == ifidrs || (ifidusert && idexrt == ifidrt));
        if (lu) return 7'b0001110;
        return 7'b1101010;
    endfunction

    task automatic step(input logic r, input logic mrd, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic br, input logic req, input logic rdy);
        bit         frz;
        logic [6:0] e;
        rst = r; idexmemrd = mrd; idexrt = xrt; ifidrs = rs; ifidrt = rt;
        ifidusert = urt; branchtaken = br; dmemreq = req; dmemready = rdy;
        frz = m_wait ? !(req && rdy) : (req && !rdy);
        e = expect_ctrl(frz);
        #3;
        chk("ctrl", {pcwrite, ifidwrite, ifidflush, idexwrite, idexbubble, exmemwrite, memwbbubble}, e);
        if (m_known) begin
            chk("stallcycles", stallcycles, m_stall);
            chk("memerr", memerr, m_err);
        end
        @(posedge clk);
        if (r) begin
            m_known = 1; m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0;
        end else begin
            if (!e[6]) m_stall = (m_stall < STALL_MAX) ? m_stall + 1 : STALL_MAX;
            if (m_wait && frz) begin
                m_wcnt++;
                if (m_wcnt == TIMEOUT) m_err = 1;
            end else begin
                m_wcnt = 0;
            end
            m_wait = frz;
        end
        #1;
    endtask

    task automatic idle(input logic r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        @(posedge clk); #1;
        idle(1); idle(1);
        chk("reset_stall", stallcycles, 0);
        chk("reset_memerr", memerr, 0);

        // lw $2 ; add $3,$2,$4
        step(0, 1, 2, 2, 4, 1, 0, 0, 0);
        idle(0);
        // addi reads rt field as destination, sw reads it as source
        step(0, 1, 2, 7, 2, 0, 0, 0, 0);
        step(0, 1, 2, 7, 2, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        // load-use masked by taken branch
        step(0, 1, 5, 5, 5, 1, 1, 0, 0);

        // three freeze cycles then release, branch deferred across the wait
        idle(1);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1);
        chk("freeze_stall3", stallcycles, 3);
        // back-to-back access re-enters the wait directly
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);

        // timeout: entry cycle plus four MEM_WAIT cycles
        idle(1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("timeout_memerr", memerr, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        chk("timeout_cleared", memerr, 0);
        idle(0);

        // stall counter saturation, then reset in the middle of a wait
        idle(1);
        for (int i = 0; i < 20; i++) step(0, 1, 3, 3, 0, 0, 0, 0, 0);
        chk("stall_sat", stallcycles, STALL_MAX);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        chk("rst_in_wait", stallcycles, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 2),
                 ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 9) < 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
